// File: rtl/pkt_prio_sched.sv
// Four-class strict-priority scheduler: sorts prioritized entries into per-class FIFOs and
// re-issues them through a registered valid/ready stage. Optional aging: PRIO_SCHED_AGING_EN.
module pkt_prio_sched #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STARVE_LIM = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [5:0]        in_prior,
  output logic              in_deque_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [5:0]        out_prior,
  output logic [15:0]       drop_zero_cnt,
  output logic [15:0]       drop_full_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DWIDTH + 6;

  logic [EW-1:0]     mem_q [4][DEPTH];
  logic [AW:0]       wr_ptr_q [4];
  logic [AW:0]       wr_ptr_d [4];
  logic [AW:0]       rd_ptr_q [4];
  logic [AW:0]       rd_ptr_d [4];
  logic [3:0]        full, nonempty, pop;
  logic [1:0]        in_cls, hi_cls, lo_cls, sel_cls;
  logic              in_zero, load, grant, push_ok;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [5:0]        out_prior_q, out_prior_d;
  logic [15:0]       drop_zero_q, drop_zero_d, drop_full_q, drop_full_d;

`ifdef PRIO_SCHED_AGING_EN
  localparam logic [3:0] AgeLim = 4'(STARVE_LIM);
  logic [3:0] age_q, age_d;
  logic       force_lo;
`endif

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      nonempty[c] = (wr_ptr_q[c] != rd_ptr_q[c]);
      full[c]     = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                    (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
    end
    hi_cls = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (nonempty[c]) hi_cls = 2'(c);
    end
    lo_cls = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (nonempty[c]) lo_cls = 2'(c);
    end
  end

  assign load  = ~out_valid_q | out_ready;
  assign grant = load & (|nonempty);

`ifdef PRIO_SCHED_AGING_EN
  // Counter at the limit forces one grant to the lowest waiting class.
  always_comb begin
    force_lo = (age_q >= AgeLim);
    sel_cls  = force_lo ? lo_cls : hi_cls;
    age_d    = age_q;
    if (grant) begin
      if (force_lo || (sel_cls == lo_cls)) begin
        age_d = 4'd0;
      end else if (age_q != 4'hF) begin
        age_d = age_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= 4'd0;
    else     age_q <= age_d;
  end
`else
  assign sel_cls = hi_cls;
`endif

  always_comb begin
    pop     = grant ? (4'b0001 << sel_cls) : 4'b0000;
    in_cls  = in_prior[5:4];
    in_zero = (in_prior == 6'd0);
    // A same-cycle pop of the target class frees the slot being written.
    push_ok = in_valid & ~in_zero & (~full[in_cls] | pop[in_cls]);

    for (int c = 0; c < 4; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      if (push_ok && (in_cls == 2'(c))) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      if (pop[c])                       rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
    end

    drop_zero_d = drop_zero_q;
    drop_full_d = drop_full_q;
    if (in_valid && in_zero && (drop_zero_q != 16'hFFFF)) begin
      drop_zero_d = drop_zero_q + 16'd1;
    end
    if (in_valid && !in_zero && full[in_cls] && !pop[in_cls] && (drop_full_q != 16'hFFFF)) begin
      drop_full_d = drop_full_q + 16'd1;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_prior_d = out_prior_q;
    if (load) begin
      out_valid_d = |nonempty;
      if (|nonempty) begin
        {out_data_d, out_prior_d} = mem_q[sel_cls][rd_ptr_q[sel_cls][AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[in_cls][wr_ptr_q[in_cls][AW-1:0]] <= {in_data, in_prior};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prior_q <= '0;
      drop_zero_q <= '0;
      drop_full_q <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prior_q <= out_prior_d;
      drop_zero_q <= drop_zero_d;
      drop_full_q <= drop_full_d;
    end
  end

  assign in_deque_en   = ~full[in_cls];
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_prior     = out_prior_q;
  assign drop_zero_cnt = drop_zero_q;
  assign drop_full_cnt = drop_full_q;

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Directed bench for pkt_prio_sched; inputs driven and outputs sampled on the falling edge.
// Define PRIO_SCHED_AGING_EN to exercise the aging scenario instead of pure strict priority.
module tb_pkt_prio_sched;
  localparam int unsigned DWIDTH = 32;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DWIDTH-1:0] in_data = '0;
  logic [5:0]        in_prior = '0;
  logic              in_deque_en;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DWIDTH-1:0] out_data;
  logic [5:0]        out_prior;
  logic [15:0]       drop_zero_cnt, drop_full_cnt;

  int errors = 0;
  int checks = 0;

  pkt_prio_sched #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .STARVE_LIM(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_prior(in_prior),
    .in_deque_en(in_deque_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_prior(out_prior),
    .drop_zero_cnt(drop_zero_cnt), .drop_full_cnt(drop_full_cnt)
  );

  always #5 clk = ~clk;

  // Presents one entry for exactly one rising edge; starts and ends on a falling edge.
  task automatic push(input logic [5:0] p, input logic [31:0] d);
    in_valid = 1'b1; in_prior = p; in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    in_prior = 6'h10; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
    checks++; if (out_prior !== 6'h0) begin errors++; $display("FAIL rst_prior got %h exp 0", out_prior); end
    checks++; if (drop_zero_cnt !== 16'h0) begin errors++; $display("FAIL rst_dz got %0d exp 0", drop_zero_cnt); end
    checks++; if (drop_full_cnt !== 16'h0) begin errors++; $display("FAIL rst_df got %0d exp 0", drop_full_cnt); end
    checks++; if (in_deque_en !== 1'b1) begin errors++; $display("FAIL rst_deq got %b exp 1", in_deque_en); end
    @(negedge clk);
  endtask

  // Filler occupies the output register so A and B both wait in their FIFOs.
  task automatic test_priority();
    logic [31:0] exp_d [3];
    logic [5:0]  exp_p [3];
    exp_d = '{32'hF111, 32'hB0B0, 32'hA0A0};
    exp_p = '{6'h01, 6'h35, 6'h05};
    do_reset();
    push(6'h01, 32'hF111);
    push(6'h05, 32'hA0A0);
    push(6'h35, 32'hB0B0);
    checks++; if (out_data !== 32'hF111) begin errors++; $display("FAIL prio_hold got %h exp f111", out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_prior !== exp_p[k]) begin
        errors++;
        $display("FAIL prio_out%0d got v=%b d=%h p=%h exp v=1 d=%h p=%h", k, out_valid, out_data,
                 out_prior, exp_d[k], exp_p[k]);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full_drop();
    do_reset();
    push(6'h01, 32'hF222);
    for (int i = 0; i < DEPTH + 2; i++) push(6'h10, 32'(i));
    in_prior = 6'h10; #1;
    checks++; if (in_deque_en !== 1'b0) begin errors++; $display("FAIL full_deq got %b exp 0", in_deque_en); end
    in_prior = 6'h20; #1;
    checks++; if (in_deque_en !== 1'b1) begin errors++; $display("FAIL other_deq got %b exp 1", in_deque_en); end
    checks++; if (drop_full_cnt !== 16'd2) begin errors++; $display("FAIL full_cnt got %0d exp 2", drop_full_cnt); end
    checks++; if (drop_zero_cnt !== 16'd0) begin errors++; $display("FAIL full_zcnt got %0d exp 0", drop_zero_cnt); end
    @(negedge clk);
    out_ready = 1'b1;
    checks++; if (out_data !== 32'hF222) begin errors++; $display("FAIL full_first got %h exp f222", out_data); end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++; $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, i);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_zero_drop();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(6'h00, 32'hDEAD0000 + 32'(i));
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_out got %b exp 0", out_valid); end
      @(negedge clk);
    end
    checks++; if (drop_zero_cnt !== 16'd3) begin errors++; $display("FAIL zero_cnt got %0d exp 3", drop_zero_cnt); end
  endtask

  // Full class written every cycle while draining: each write rides on a same-cycle pop.
  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) push(6'h20, 32'd100 + 32'(i));
    in_prior = 6'h20; #1;
    checks++; if (in_deque_en !== 1'b0) begin errors++; $display("FAIL b2b_deq got %b exp 0", in_deque_en); end
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 11; k++) begin
      exp = (k <= DEPTH) ? 32'd100 + 32'(k) : 32'd200 + 32'(k - DEPTH - 1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++; $display("FAIL b2b_out%0d got v=%b d=%0d exp v=1 d=%0d", k, out_valid, out_data, exp);
      end
      in_valid = (k < 10); in_prior = 6'h20; in_data = 32'd200 + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
    checks++; if (drop_full_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop got %0d exp 0", drop_full_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push(6'h01, 32'hF333);
    push(6'h30, 32'h1); push(6'h20, 32'h2); push(6'h10, 32'h3); push(6'h31, 32'h4);
    push(6'h05, 32'h5);
    push(6'h00, 32'h6);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    checks++; if (drop_zero_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 1", drop_zero_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (drop_zero_cnt !== 16'd0 || drop_full_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", drop_zero_cnt, drop_full_cnt);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b exp 0", i, out_valid); end
    end
  endtask

`ifdef PRIO_SCHED_AGING_EN
  // Class 3 never drains; class 0 entry C must win the 16th grant after the filler.
  task automatic test_aging();
    do_reset();
    push(6'h02, 32'hF444);
    push(6'h03, 32'hCCCC);
    for (int i = 0; i < DEPTH; i++) push(6'h30, 32'd300 + 32'(i));
    out_ready = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      if (k == 0) begin
        checks++; if (out_data !== 32'hF444) begin errors++; $display("FAIL age_fill got %h exp f444", out_data); end
      end else if (k == 16) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hCCCC || out_prior !== 6'h03) begin
          errors++; $display("FAIL age_c got v=%b d=%h p=%h exp v=1 d=cccc p=03", out_valid, out_data, out_prior);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_prior !== 6'h30) begin
          errors++; $display("FAIL age_hi%0d got v=%b p=%h exp v=1 p=30", k, out_valid, out_prior);
        end
      end
      in_valid = 1'b1; in_prior = 6'h30; in_data = 32'd400 + 32'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask
`else
  task automatic test_strict();
    logic [31:0] exp_d [6];
    exp_d = '{32'hF444, 32'd300, 32'd301, 32'd302, 32'd303, 32'hCCCC};
    do_reset();
    push(6'h02, 32'hF444);
    push(6'h03, 32'hCCCC);
    for (int i = 0; i < 4; i++) push(6'h30, 32'd300 + 32'(i));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin
        errors++; $display("FAIL strict_out%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_d[k]);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL strict_empty got %b exp 0", out_valid); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_priority();
    test_full_drop();
    test_zero_drop();
    test_back_to_back();
    test_mid_reset();
`ifdef PRIO_SCHED_AGING_EN
    test_aging();
`else
    test_strict();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
